// File: rtl/burst_capture_buffer_if.sv
// Bus bundle for burst_capture_buffer: capture input, replay output and status.
// The slave modport is the buffer side; the master modport is the
// producer/consumer side that drives start, input beats and out_ready.
interface burst_capture_buffer_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [1:0]       state_o;
    logic             busy;
    logic [LVL_W-1:0] level;

    modport slave (
        input  start, in_valid, in_data, out_ready,
        output out_valid, out_data, state_o, busy, level
    );

    modport master (
        output start, in_valid, in_data, out_ready,
        input  out_valid, out_data, state_o, busy, level
    );
endinterface

// File: rtl/burst_capture_buffer.sv
// burst_capture_buffer: captures exactly DEPTH input beats after a start
// pulse, then replays them in order on a valid/ready port and returns to IDLE.
// Optional feature: define BURST_CAPTURE_DROP_CNT_EN to add the drop_cnt
// port, a saturating count of input beats offered outside the FILL state.
module burst_capture_buffer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    burst_capture_buffer_if.slave  bus
`ifdef BURST_CAPTURE_DROP_CNT_EN
    ,
    output logic [7:0]             drop_cnt
`endif
);
    localparam int LVL_W = $clog2(DEPTH + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        FILL  = 2'b01,
        DRAIN = 2'b10
    } state_t;

    state_t           state;
    state_t           state_n;
    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] wr_ptr_n;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_n;
    logic [LVL_W-1:0] level;
    logic [LVL_W-1:0] level_n;
    logic             wr_en;
    logic             pop;
    logic             out_valid_q;
    logic             out_valid_n;
    logic [WIDTH-1:0] out_data_q;
    logic [WIDTH-1:0] out_data_n;
    logic [WIDTH-1:0] head_n;
    logic             busy_q;

    // Next-state, pointer and level decisions for the IDLE/FILL/DRAIN control
    always_comb begin
        state_n  = state;
        wr_ptr_n = wr_ptr;
        rd_ptr_n = rd_ptr;
        level_n  = level;
        wr_en    = 1'b0;
        pop      = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    state_n  = FILL;
                    wr_ptr_n = '0;
                    rd_ptr_n = '0;
                    level_n  = '0;
                end
            end
            FILL: begin
                if (bus.in_valid) begin
                    wr_en    = 1'b1;
                    wr_ptr_n = wr_ptr + PTR_W'(1);
                    level_n  = level + LVL_W'(1);
                    if (level == LVL_W'(DEPTH - 1)) begin
                        state_n = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (out_valid_q && bus.out_ready && (level != '0)) begin
                    pop      = 1'b1;
                    rd_ptr_n = rd_ptr + PTR_W'(1);
                    level_n  = level - LVL_W'(1);
                    if (level == LVL_W'(1)) begin
                        state_n = IDLE;
                    end
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Registered output values; the head word bypasses the array when it is
    // being written on the same edge it becomes visible
    always_comb begin
        head_n      = (wr_en && (wr_ptr == rd_ptr_n)) ? bus.in_data : mem[rd_ptr_n];
        out_valid_n = (state_n == DRAIN) && (level_n != '0);
        out_data_n  = out_valid_n ? head_n : '0;
    end

    // Control state, pointers, level and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            level       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state       <= state_n;
            wr_ptr      <= wr_ptr_n;
            rd_ptr      <= rd_ptr_n;
            level       <= level_n;
            out_valid_q <= out_valid_n;
            out_data_q  <= out_data_n;
            busy_q      <= (state_n != IDLE);
        end
    end

    // Capture storage; contents survive reset and are simply overwritten
    always_ff @(posedge clk) begin
        if (!rst && wr_en) begin
            mem[wr_ptr] <= bus.in_data;
        end
    end

`ifdef BURST_CAPTURE_DROP_CNT_EN
    // Saturating count of beats offered while not filling
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt <= 8'h00;
        end else if (bus.in_valid && (state != FILL) && (drop_cnt != 8'hFF)) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end
`endif

    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.state_o   = state;
    assign bus.busy      = busy_q;
    assign bus.level     = level;

endmodule

// File: tb/tb_burst_capture_buffer.sv
// Testbench for burst_capture_buffer (WIDTH=8, DEPTH=4): a table of directed
// vectors, hand-written corner sequences and randomized traffic, all checked
// against a queue-based reference model. Drop counter checks are compiled in
// when BURST_CAPTURE_DROP_CNT_EN is defined.
module tb_burst_capture_buffer;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH + 1);

    logic clk;
    logic rst;
`ifdef BURST_CAPTURE_DROP_CNT_EN
    logic [7:0] drop_cnt;
`endif

    burst_capture_buffer_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    burst_capture_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus)
`ifdef BURST_CAPTURE_DROP_CNT_EN
        ,
        .drop_cnt (drop_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    // Reference model: mode 0=idle, 1=filling, 2=draining; captured words in a queue
    int         mode = 0;
    logic [7:0] mq[$];
    int         drop_model = 0;

    typedef struct {
        logic       r;
        logic       s;
        logic       iv;
        logic [7:0] d;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic [1:0] es;
        logic [2:0] el;
    } vec_t;

    vec_t vecs[12];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOne(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic modelUpdate(input logic r, input logic s, input logic iv,
                               input logic [7:0] d, input logic rdy);
        if (r) begin
            mode = 0;
            mq.delete();
            drop_model = 0;
        end else begin
            if (iv && mode != 1 && drop_model < 255) drop_model++;
            case (mode)
                0: if (s) begin
                    mode = 1;
                    mq.delete();
                end
                1: if (iv) begin
                    mq.push_back(d);
                    if (mq.size() == DEPTH) mode = 2;
                end
                default: if (rdy && mq.size() != 0) begin
                    void'(mq.pop_front());
                    if (mq.size() == 0) mode = 0;
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic s, input logic iv,
                                 input logic [7:0] d, input logic rdy);
        @(negedge clk);
        rst           = r;
        bus.start     = s;
        bus.in_valid  = iv;
        bus.in_data   = d;
        bus.out_ready = rdy;
        @(posedge clk);
        modelUpdate(r, s, iv, d, rdy);
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic       ev;
        logic [7:0] ed;
        ev = (mode == 2) && (mq.size() != 0);
        ed = ev ? mq[0] : 8'h00;
        checkOne({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ev));
        checkOne({tag, ".out_data"},  32'(bus.out_data),  32'(ed));
        checkOne({tag, ".state_o"},   32'(bus.state_o),   32'(mode));
        checkOne({tag, ".level"},     32'(bus.level),     32'(mq.size()));
        checkOne({tag, ".busy"},      32'(bus.busy),      32'(mode != 0));
`ifdef BURST_CAPTURE_DROP_CNT_EN
        checkOne({tag, ".drop_cnt"},  32'(drop_cnt),      32'(drop_model));
`endif
    endtask

    task automatic fillBurst(input logic [7:0] base, input string tag);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput(tag);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, base + 8'(k), 1'b0);
            checkOutput(tag);
        end
    endtask

    initial begin
        rst           = 1'b1;
        bus.start     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        //           r  s  iv  d      rdy ev  ed     es     el
        vecs[0]  = '{1, 0, 0, 8'h00, 0,  0, 8'h00, 2'b00, 3'd0};
        vecs[1]  = '{1, 0, 0, 8'h00, 0,  0, 8'h00, 2'b00, 3'd0};
        vecs[2]  = '{0, 1, 1, 8'h99, 0,  0, 8'h00, 2'b01, 3'd0};
        vecs[3]  = '{0, 0, 1, 8'h11, 0,  0, 8'h00, 2'b01, 3'd1};
        vecs[4]  = '{0, 1, 1, 8'h22, 0,  0, 8'h00, 2'b01, 3'd2};
        vecs[5]  = '{0, 0, 1, 8'h33, 0,  0, 8'h00, 2'b01, 3'd3};
        vecs[6]  = '{0, 0, 1, 8'h44, 1,  1, 8'h11, 2'b10, 3'd4};
        vecs[7]  = '{0, 1, 1, 8'h55, 1,  1, 8'h22, 2'b10, 3'd3};
        vecs[8]  = '{0, 0, 0, 8'h00, 1,  1, 8'h33, 2'b10, 3'd2};
        vecs[9]  = '{0, 0, 0, 8'h00, 1,  1, 8'h44, 2'b10, 3'd1};
        vecs[10] = '{0, 1, 0, 8'h00, 1,  0, 8'h00, 2'b00, 3'd0};
        vecs[11] = '{0, 0, 0, 8'h00, 1,  0, 8'h00, 2'b00, 3'd0};

        $display("[TB] directed vector table");
        for (int i = 0; i < 12; i++) begin
            applyStimulus(vecs[i].r, vecs[i].s, vecs[i].iv, vecs[i].d, vecs[i].rdy);
            checkOne($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(vecs[i].ev));
            checkOne($sformatf("vec%0d.out_data", i),  32'(bus.out_data),  32'(vecs[i].ed));
            checkOne($sformatf("vec%0d.state_o", i),   32'(bus.state_o),   32'(vecs[i].es));
            checkOne($sformatf("vec%0d.level", i),     32'(bus.level),     32'(vecs[i].el));
            checkOne($sformatf("vec%0d.busy", i),      32'(bus.busy),      32'(vecs[i].es != 2'b00));
        end

        $display("[TB] input gaps");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        checkOutput("gap");
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h11 * 8'(k + 1), 1'b0);
            checkOutput("gap");
            checkOne("gap.level_step", 32'(bus.level), 32'(k + 1));
            applyStimulus(1'b0, 1'b0, 1'b0, 8'hEE, 1'b0);
            checkOutput("gap");
        end
        checkOne("gap.in_drain", 32'(bus.state_o), 32'(2'b10));

        $display("[TB] backpressure");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            checkOutput("bp");
            checkOne("bp.hold_data", 32'(bus.out_data), 32'h11);
            checkOne("bp.hold_level", 32'(bus.level), 32'd4);
        end
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("bp_drain");
        end
        checkOne("bp.back_idle", 32'(bus.state_o), 32'(2'b00));

        $display("[TB] reset mid-fill");
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h11, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h22, 1'b0);
        checkOutput("mid");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("mid_rst");
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        checkOutput("mid_idle");
        fillBurst(8'hA0, "mid_fill");
        for (int k = 0; k < DEPTH; k++) begin
            checkOne("mid.replay_data", 32'(bus.out_data), 32'(8'hA0 + 8'(k)));
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("mid_drain");
        end

`ifdef BURST_CAPTURE_DROP_CNT_EN
        $display("[TB] drop counter");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("drop_rst");
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h5A, 1'b0);
            checkOutput("drop_idle");
        end
        fillBurst(8'h30, "drop_fill");
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h77, 1'b0);
            checkOutput("drop_drain");
        end
        checkOne("drop.eight", 32'(drop_cnt), 32'd8);
        for (int k = 0; k < DEPTH; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
            checkOutput("drop_empty");
        end
        for (int k = 0; k < 300; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 8'h00, 1'b0);
        end
        checkOutput("drop_sat");
        checkOne("drop.saturate", 32'(drop_cnt), 32'hFF);
`endif

        $display("[TB] randomized traffic");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        checkOutput("rnd_rst");
        for (int n = 0; n < 2000; n++) begin
            applyStimulus(($urandom_range(0, 99) == 0),
                          ($urandom_range(0, 3) == 0),
                          ($urandom_range(0, 1) == 1),
                          8'($urandom),
                          ($urandom_range(0, 2) != 0));
            checkOutput("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
